spi_slave: RTL

// - SPI responder (mode 0: CPOL=0, CPHA=0, MSB first), far end of the board's SPI master link.
// - Synchronises ssel/sclk/mosi into clk, shifts in FRAME_LENGTH-bit frames and returns tx_data on miso.
// - Hands each received word to fabric logic through rx_data/rx_valid.
// - Reports frames cut short by early ssel release.

---
 rtl/spi_slave.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder: synchronises ssel/sclk/mosi, shifts fixed-length
// frames MSB first, returns tx_data on miso, reports early ssel release.
// Ports: clk, rst_n (async low); ssel, sclk, mosi in; miso out;
//   tx_data in, tx_latched out; rx_data, rx_valid out; rx_ack in;
//   frame_abort, busy out; rx_overrun out with SPI_SLAVE_OVERRUN_EN.
// Option: define SPI_SLAVE_OVERRUN_EN for held rx_valid + sticky overrun.
module spi_slave #(
  parameter int FRAME_LENGTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ssel,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  input  logic [FRAME_LENGTH-1:0] tx_data,
  output logic                    tx_latched,
  output logic [FRAME_LENGTH-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ack,
  output logic                    frame_abort,
  output logic                    busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic                    rx_overrun
`endif
);

  localparam int CW = $clog2(FRAME_LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT_END
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_ssel_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sclk_d;
  logic                   r_armed;

  logic [FRAME_LENGTH-2:0] r_tx_shift;
  logic [FRAME_LENGTH-2:0] r_rx_shift;
  logic [FRAME_LENGTH-1:0] r_rx_data;
  logic [CW-1:0]           r_bit_cnt;
  logic                    r_miso;
  logic                    r_tx_latched;
  logic                    r_frame_abort;
  logic                    r_rx_valid;

  logic w_ssel_s;
  logic w_sclk_s;
  logic w_mosi_s;
  logic w_sel;
  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_done;
  logic w_abort;
  logic w_shift_in;
  logic w_shift_out;

  assign w_ssel_s = r_ssel_sync[SYNC_STAGES-1];
  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_sel    = ~w_ssel_s;
  assign w_rise   = w_sclk_s & ~r_sclk_d;
  assign w_fall   = ~w_sclk_s & r_sclk_d;

  // r_fill marks when the sync chain holds real pin values after reset;
  // r_armed needs a genuine deselect first so a frame in flight is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ssel_sync <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_fill      <= '0;
      r_sclk_d    <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], ssel};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
      if (r_fill[SYNC_STAGES-1] && w_ssel_s)
        r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Last rise wins over a simultaneous deselect: the frame completes.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_shift_in  = 1'b0;
    w_shift_out = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_armed && w_sel) begin
          w_start = 1'b1;
          w_next  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_rise && r_bit_cnt == LAST) begin
          w_done = 1'b1;
          w_next = WAIT_END;
        end else if (!w_sel) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (w_rise) begin
          w_shift_in = 1'b1;
        end else if (w_fall && r_bit_cnt != '0) begin
          w_shift_out = 1'b1;
        end
      end
      WAIT_END: begin
        if (!w_sel) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // tx_shift keeps only the bits still to be sent after the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_bit_cnt     <= '0;
      r_miso        <= 1'b0;
      r_tx_latched  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_tx_latched  <= w_start;
      r_frame_abort <= w_abort;
      if (w_start) begin
        r_tx_shift <= tx_data[FRAME_LENGTH-2:0];
        r_miso     <= tx_data[FRAME_LENGTH-1];
        r_bit_cnt  <= '0;
      end
      if (w_shift_in) begin
        r_rx_shift <= {r_rx_shift[FRAME_LENGTH-3:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + CW'(1);
      end
      if (w_shift_out) begin
        r_tx_shift <= {r_tx_shift[FRAME_LENGTH-3:0], 1'b0};
        r_miso     <= r_tx_shift[FRAME_LENGTH-2];
      end
      if (w_done || w_abort)
        r_miso <= 1'b0;
      if (w_done)
        r_rx_data <= {r_rx_shift, w_mosi_s};
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_rx_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else if (w_done) begin
      r_rx_valid <= 1'b1;
      if (r_rx_valid && !rx_ack)
        r_rx_overrun <= 1'b1;
    end else if (rx_ack) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign rx_overrun = r_rx_overrun;
`else
  logic w_unused_ack;
  assign w_unused_ack = rx_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_valid <= 1'b0;
    else        r_rx_valid <= w_done;
  end
`endif

  assign miso        = r_miso;
  assign tx_latched  = r_tx_latched;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_abort = r_frame_abort;
  assign busy        = (r_state != IDLE);

endmodule
